// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, framing/overrun
// detection and a one-byte holding register on a valid/ready interface.
module uart_rx_byte #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       CK_RST,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int BIT_CNT  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT + 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_err_q, overrun_err_d;
  logic            cnt_zero;
  logic            byte_done;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    valid_d       = valid_q;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    byte_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      // A start bit that is high again at its mid-point was only a glitch.
      START: begin
        if (cnt_zero) begin
          if (!rx_s_q) begin
            cnt_d   = BIT_LOAD;
            idx_d   = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = BIT_LOAD;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // Wait out a held-low line so a break yields one error, not a stream of frames.
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    // A consumer draining in the completion cycle frees the register for the new byte.
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge CK_RST) begin
    if (!CK_RST) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      rx_s_q        <= 1'b1;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shift_q       <= 8'h00;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= UART_RX;
      rx_s_q        <= sync1_q;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: frame-level model of the holding register checked every
// cycle, plus directed literal checks on reset, latency, overrun, framing and glitches.
module tb_uart_rx_byte;

  localparam int BIT  = 16;
  localparam int HALF = 8;
  // Edges from the start-bit fall to the stop-bit decision becoming visible.
  localparam int LAT  = 3 + HALF + 9 * BIT;

  logic       CLK = 1'b0;
  logic       CK_RST = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_count = 0;
  int oe_count = 0;
  int vr_count = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       stop_ok;
  } ev_t;

  ev_t        evq[$];
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       ready_prev = 1'b0;
  logic       valid_prev = 1'b0;

  uart_rx_byte #(
    .CLK_FREQ(1600000),
    .BAUD    (100000)
  ) dut (
    .CLK        (CLK),
    .CK_RST     (CK_RST),
    .UART_RX    (UART_RX),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives the first nbits of a frame (start, 8 data LSB first, stop); full frames
  // can register the outcome the model should expect.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_ok,
                               input int nbits, input bit expect_it);
    ev_t ev;
    if (expect_it) begin
      ev.due     = cyc + LAT;
      ev.data    = data;
      ev.stop_ok = stop_ok;
      evq.push_back(ev);
    end
    for (int b = 0; b < nbits; b++) begin
      if (b == 0) UART_RX = 1'b0;
      else if (b == 9) UART_RX = stop_ok;
      else UART_RX = data[b-1];
      waitCycles(BIT);
    end
    if (nbits == 10) UART_RX = 1'b1;
  endtask

  task automatic holdBreak(input int nbits);
    ev_t ev;
    ev.due     = cyc + LAT;
    ev.data    = 8'h00;
    ev.stop_ok = 1'b0;
    evq.push_back(ev);
    UART_RX = 1'b0;
    waitCycles(nbits * BIT);
    UART_RX = 1'b1;
  endtask

  // Model of the holding register, updated for the edge just passed, then compared.
  always @(negedge CLK) begin
    logic hs, old_valid, fe_exp, oe_exp;
    fe_exp = 1'b0;
    oe_exp = 1'b0;
    if (!CK_RST) begin
      evq.delete();
      exp_valid = 1'b0;
      exp_data  = 8'h00;
    end else begin
      old_valid = exp_valid;
      hs = exp_valid && ready_prev;
      if (hs) exp_valid = 1'b0;
      if (evq.size() > 0 && evq[0].due == cyc) begin
        if (!evq[0].stop_ok) begin
          fe_exp = 1'b1;
        end else if (!old_valid || hs) begin
          exp_data  = evq[0].data;
          exp_valid = 1'b1;
        end else begin
          oe_exp = 1'b1;
        end
        void'(evq.pop_front());
      end
    end
    checkOutput("model_rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
    checkOutput("model_rx_data", {24'd0, rx_data}, {24'd0, exp_data});
    checkOutput("model_frame_err", {31'd0, frame_err}, {31'd0, fe_exp});
    checkOutput("model_overrun_err", {31'd0, overrun_err}, {31'd0, oe_exp});
    if (frame_err === 1'b1) fe_count++;
    if (overrun_err === 1'b1) oe_count++;
    if (rx_valid === 1'b1 && !valid_prev) vr_count++;
    valid_prev = (rx_valid === 1'b1);
    ready_prev = rx_ready;
  end

  initial begin
    #2 CK_RST = 1'b0;
    waitCycles(5);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_overrun_err", {31'd0, overrun_err}, 32'd0);
    CK_RST = 1'b1;
    waitCycles(100);
    checkOutput("idle_no_valid", vr_count, 32'd0);
    checkOutput("idle_no_errors", fe_count + oe_count, 32'd0);

    // Single byte with exact latency pinned by hand.
    rx_ready = 1'b1;
    fork
      applyStimulus(8'hA5, 1'b1, 10, 1'b1);
      begin
        waitCycles(154);
        checkOutput("a5_not_yet_valid", {31'd0, rx_valid}, 32'd0);
        waitCycles(1);
        checkOutput("a5_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("a5_data", {24'd0, rx_data}, 32'hA5);
        waitCycles(1);
        checkOutput("a5_one_cycle", {31'd0, rx_valid}, 32'd0);
      end
    join
    waitCycles(20);

    applyStimulus(8'h00, 1'b1, 10, 1'b1);
    applyStimulus(8'hFF, 1'b1, 10, 1'b1);
    applyStimulus(8'h55, 1'b1, 10, 1'b1);
    waitCycles(20);
    checkOutput("b2b_valid_pulses", vr_count, 32'd4);
    checkOutput("b2b_no_errors", fe_count + oe_count, 32'd0);

    // Overrun: the second byte is dropped while the first is held.
    rx_ready = 1'b0;
    applyStimulus(8'h12, 1'b1, 10, 1'b1);
    applyStimulus(8'h34, 1'b1, 10, 1'b1);
    waitCycles(2);
    checkOutput("ovr_held_data", {24'd0, rx_data}, 32'h12);
    checkOutput("ovr_held_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("ovr_pulse_count", oe_count, 32'd1);
    rx_ready = 1'b1;
    waitCycles(1);
    rx_ready = 1'b0;
    checkOutput("ovr_drained", {31'd0, rx_valid}, 32'd0);

    applyStimulus(8'h12, 1'b1, 10, 1'b1);
    fork
      applyStimulus(8'h34, 1'b1, 10, 1'b1);
      begin
        waitCycles(154);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
      end
    join
    checkOutput("simul_data", {24'd0, rx_data}, 32'h34);
    checkOutput("simul_valid", {31'd0, rx_valid}, 32'd1);
    checkOutput("simul_no_overrun", oe_count, 32'd1);
    rx_ready = 1'b1;
    waitCycles(2);

    applyStimulus(8'h3C, 1'b0, 10, 1'b1);
    waitCycles(20);
    checkOutput("frame_err_count", fe_count, 32'd1);
    checkOutput("frame_no_valid", {31'd0, rx_valid}, 32'd0);

    holdBreak(40);
    waitCycles(32);
    checkOutput("break_one_err", fe_count, 32'd2);
    rx_ready = 1'b0;
    applyStimulus(8'h81, 1'b1, 10, 1'b1);
    waitCycles(5);
    checkOutput("after_break_data", {24'd0, rx_data}, 32'h81);

    UART_RX = 1'b0;
    waitCycles(4);
    UART_RX = 1'b1;
    waitCycles(200);
    checkOutput("glitch_no_err", fe_count, 32'd2);
    checkOutput("glitch_keeps_data", {24'd0, rx_data}, 32'h81);

    // Reset in the middle of a frame clears everything at once.
    applyStimulus(8'hC3, 1'b1, 5, 1'b0);
    CK_RST = 1'b0;
    #1;
    checkOutput("midreset_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("midreset_data", {24'd0, rx_data}, 32'd0);
    UART_RX = 1'b1;
    waitCycles(3);
    CK_RST = 1'b1;
    rx_ready = 1'b1;
    waitCycles(10);
    applyStimulus(8'h7E, 1'b1, 10, 1'b1);
    waitCycles(5);
    checkOutput("post_reset_data", {24'd0, rx_data}, 32'h7E);

    checkOutput("total_valid_rises", vr_count, 32'd8);
    checkOutput("total_frame_errs", fe_count, 32'd2);
    checkOutput("total_overruns", oe_count, 32'd1);
    checkOutput("model_queue_empty", evq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Receives 8N1 serial data from the board UART_RX pin and presents each received byte on a valid/ready byte interface.
- Sits directly downstream of the board top-level UART_RX input and upstream of user logic; for example, a loopback path to the UART transmitter or an LED/command decoder.
- Includes an input synchronizer, mid-bit sampling, framing-error and overrun detection, and a one-byte holding register.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate in bit/s.
- BIT_CNT (local), (CLK_FREQ + BAUD/2) / BAUD, clocks per bit; 868 at defaults.
- HALF_CNT (local), BIT_CNT / 2, clocks to mid-bit; 434 at defaults.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- CK_RST  input  1  reset; asynchronous assert, active-low.
- UART_RX  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte, LSB first on the line; valid while rx_valid=1.
- rx_valid  output  1  holding register contains an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte; the handshake completes on a cycle with rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: byte completed while the holding register was full and not being drained.

Behaviour:
- Reset (CK_RST=0, asynchronous):
  - FSM goes to IDLE.
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun_err=0.
  - Synchronizer flops set to 1, so no false start is detected on release.
  - Bit counter and shift register are cleared.
  - A reset mid-frame abandons the frame; no partial byte is ever presented.
- Synchronizer: two flops on UART_RX produce rx_s. All decisions use rx_s only, so there are 2 cycles of input latency.
- Bit timer: a counter runs down from its load value to 0. Its width is clog2(BIT_CNT+1).
- FSM states and transitions:
  - IDLE: on rx_s=0, load the counter with HALF_CNT-1 and go to START.
  - START: when the counter reaches 0, sample rx_s.
    - rx_s=0: load BIT_CNT-1, clear the bit index, go to DATA.
    - rx_s=1: glitch; return to IDLE with no error.
  - DATA: each time the counter reaches 0, shift rx_s into bit[index] (LSB first) and reload BIT_CNT-1.
    - After index 7, go to STOP.
  - STOP: when the counter reaches 0, sample rx_s.
    - rx_s=1: byte complete; go to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. This prevents a held-low line (break) from generating repeated frames.
- Byte completion, in the cycle after the stop-bit sample:
  - If rx_valid=0, or rx_valid & rx_ready in that same cycle: load rx_data and set rx_valid=1. The simultaneous case is not an overrun.
  - Else: keep the old byte, drop the new one, pulse overrun_err for 1 cycle.
- Handshake:
  - rx_valid stays high and rx_data stays stable until the handshake completes.
  - rx_valid clears the cycle after rx_valid & rx_ready, unless a new byte loads in that cycle.
  - rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises 1 cycle after the stop-bit mid-point sample, about 9.5 bit times plus 3 cycles after the start-bit falling edge on UART_RX.
- Back-to-back frames: IDLE is re-entered at the stop-bit mid-point, so a start edge arriving half a bit later is caught. Baud error tolerance is ±4%.
- frame_err and overrun_err never assert in the same cycle.

Test Plan (bench parameters CLK_FREQ=1600000, BAUD=100000, so BIT_CNT=16, HALF_CNT=8):
- Reset: hold CK_RST=0 with UART_RX=1 -> all outputs 0. Release; 100 idle cycles -> no rx_valid and no error pulses.
- Single byte 8'hA5, rx_ready=1 -> rx_valid high for exactly 1 cycle with rx_data=8'hA5, 1 cycle after the stop sample (about 155 cycles after the start edge).
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap, rx_ready=1 -> three valid pulses in order, no errors.
- Overrun: rx_ready=0, send 8'h12 then 8'h34 -> rx_data stays 8'h12, one overrun_err pulse. Then assert rx_ready -> 8'h12 is accepted, rx_valid drops. Also drive rx_ready=1 exactly in the cycle 8'h34 completes -> 8'h34 is loaded, no overrun_err.
- Framing/break:
  - Send 8'h3C with the stop bit low -> one frame_err pulse, no rx_valid.
  - Hold the line low for 40 bit times -> exactly one frame_err; after the line returns high, 8'h81 is received correctly.
- Glitch and mid-frame reset:
  - A 4-cycle low pulse on UART_RX -> no rx_valid, no error.
  - Assert CK_RST in DATA after 4 bits of 8'hC3 -> outputs go to 0 immediately; after release, the next full frame 8'h7E is received correctly.
